// File: rtl/reg_pkg.sv
// reg_pkg: shared defaults and helpers for the register-file family
package reg_pkg;

    localparam int REG_WIDTH_DEF = 8;
    localparam int REG_DEPTH_DEF = 8;

    // Address width for n words, never narrower than one bit
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_en_n.sv
// reg_en_n: register with enable, synchronous clear and synchronous active-low reset
module reg_en_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // Reset beats clear, clear beats load, otherwise hold
    always_ff @(posedge clk) begin
        if (!reset_n)   data_q <= '0;
        else if (clr_i) data_q <= '0;
        else if (en_i)  data_q <= d_i;
    end

    assign q_o = data_q;

endmodule

// File: rtl/reg_file_nrw.sv
// reg_file_nrw: DEPTH x WIDTH register file, one write port, two registered read ports
module reg_file_nrw
    import reg_pkg::*;
#(
    parameter int  WIDTH = REG_WIDTH_DEF,
    parameter int  DEPTH = REG_DEPTH_DEF,
    localparam int AW    = clog2_min1(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re0,
    input  logic [AW-1:0]    raddr0,
    output logic [WIDTH-1:0] rdata0,
    input  logic             re1,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata1,
    output logic             addr_err
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] wen;
    logic [WIDTH-1:0] rdata0_d;
    logic [WIDTH-1:0] rdata1_d;
    logic             addr_err_d;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < (AW+1)'(DEPTH);
    endfunction

    // Write decode, read muxes with write-first bypass, and range check
    always_comb begin
        wen        = '0;
        rdata0_d   = '0;
        rdata1_d   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wen[i] = we && (waddr == AW'(i));
            if (raddr0 == AW'(i)) rdata0_d = wen[i] ? wdata : mem_q[i];
            if (raddr1 == AW'(i)) rdata1_d = wen[i] ? wdata : mem_q[i];
        end
        addr_err_d = (we && !in_range(waddr)) || (re0 && !in_range(raddr0)) || (re1 && !in_range(raddr1));
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        reg_en_n #(.WIDTH(WIDTH)) u_word (
            .clk     (clk),
            .reset_n (reset_n),
            .en_i    (wen[i]),
            .clr_i   (clr),
            .d_i     (wdata),
            .q_o     (mem_q[i])
        );
    end

    // A read during clear returns zero; an idle port keeps its value through clear
    reg_en_n #(.WIDTH(WIDTH)) u_rd0 (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (re0),
        .clr_i   (clr & re0),
        .d_i     (rdata0_d),
        .q_o     (rdata0)
    );

    reg_en_n #(.WIDTH(WIDTH)) u_rd1 (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (re1),
        .clr_i   (clr & re1),
        .d_i     (rdata1_d),
        .q_o     (rdata1)
    );

    reg_en_n #(.WIDTH(1)) u_err (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (1'b1),
        .clr_i   (1'b0),
        .d_i     (addr_err_d),
        .q_o     (addr_err)
    );

endmodule
